rx_ack_scheduler: RTL and testbench

RX_ACK_SCHEDULER -- requirements
Module: rx_ack_scheduler

---
 rtl/rx_ack_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_rx_ack_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ack_scheduler.sv
// Receive-side ACK scheduler. Tracks per-flow ACK numbers, coalesces accepted
// segments into delayed ACKs (two segments or timeout), sends duplicate ACKs
// immediately for out-of-order input, and arbitrates pending flows
// round-robin into a single held output request register.
module rx_ack_scheduler #(
    parameter int unsigned  FLOW_CNT  = 8,
    parameter int unsigned  ACK_NUM_W = 32,
    parameter int unsigned  ACK_DELAY = 64,
    localparam int unsigned FLOW_ID_W = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1,
    localparam int unsigned TIMER_W   = $clog2(ACK_DELAY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 init_val,
    input  logic [FLOW_ID_W-1:0] init_flowid,
    input  logic [ACK_NUM_W-1:0] init_ack_num,

    input  logic                 rd_req_val,
    input  logic [FLOW_ID_W-1:0] rd_req_flowid,
    output logic                 rd_resp_val,
    output logic [ACK_NUM_W-1:0] rd_resp_ack_num,

    input  logic                 upd_val,
    input  logic [FLOW_ID_W-1:0] upd_flowid,
    input  logic [ACK_NUM_W-1:0] upd_ack_num,
    input  logic                 upd_accept,

    output logic                 ack_req_val,
    output logic [FLOW_ID_W-1:0] ack_req_flowid,
    output logic [ACK_NUM_W-1:0] ack_req_ack_num,
    input  logic                 ack_req_rdy
);

    // Per-flow state
    logic [ACK_NUM_W-1:0] ack_num_q [FLOW_CNT];
    logic [ACK_NUM_W-1:0] ack_num_d [FLOW_CNT];
    logic [1:0]           seg_cnt_q [FLOW_CNT];
    logic [1:0]           seg_cnt_d [FLOW_CNT];
    logic [TIMER_W-1:0]   timer_q   [FLOW_CNT];
    logic [TIMER_W-1:0]   timer_d   [FLOW_CNT];
    logic [FLOW_CNT-1:0]  pending_q, pending_d;
    logic [FLOW_CNT-1:0]  timer_run_q, timer_run_d;

    // Arbitration and output register
    logic [FLOW_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                 out_val_q, out_val_d;
    logic [FLOW_ID_W-1:0] out_flowid_q, out_flowid_d;
    logic [ACK_NUM_W-1:0] out_ack_q, out_ack_d;

    // Lookup response register
    logic                 rd_resp_val_q;
    logic [ACK_NUM_W-1:0] rd_resp_ack_q, rd_resp_ack_d;

    logic                 load;
    logic                 sel_found;
    logic [FLOW_ID_W-1:0] sel_flow;
    logic                 upd_live;

    function automatic logic [FLOW_ID_W-1:0] flow_add(input logic [FLOW_ID_W-1:0] base,
                                                      input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % FLOW_CNT;
        return FLOW_ID_W'(sum);
    endfunction

    // Output register reloads when empty or when its request is taken
    assign load     = !out_val_q || ack_req_rdy;
    // Init to the same flow in the same cycle drops the upd
    assign upd_live = upd_val && !(init_val && (init_flowid == upd_flowid));

    // Find the first pending flow at or after rr_ptr, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_flow  = '0;
        for (int i = 0; i < int'(FLOW_CNT); i++) begin
            if (!sel_found && pending_q[flow_add(rr_ptr_q, i)]) begin
                sel_found = 1'b1;
                sel_flow  = flow_add(rr_ptr_q, i);
            end
        end
    end

    // Next-state: timer tick, then output load, then init, then upd (highest priority)
    always_comb begin
        logic [1:0] seg_new;
        seg_new      = '0;
        ack_num_d    = ack_num_q;
        seg_cnt_d    = seg_cnt_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        timer_run_d  = timer_run_q;
        rr_ptr_d     = rr_ptr_q;
        out_val_d    = out_val_q;
        out_flowid_d = out_flowid_q;
        out_ack_d    = out_ack_q;

        for (int f = 0; f < int'(FLOW_CNT); f++) begin
            if (timer_run_q[f]) begin
                timer_d[f] = timer_q[f] - TIMER_W'(1);
                if (timer_q[f] == TIMER_W'(1)) begin
                    pending_d[f]   = 1'b1;
                    timer_run_d[f] = 1'b0;
                end
            end
        end

        if (load) begin
            out_val_d = sel_found;
            if (sel_found) begin
                out_flowid_d           = sel_flow;
                out_ack_d              = ack_num_q[sel_flow];
                pending_d[sel_flow]    = 1'b0;
                seg_cnt_d[sel_flow]    = '0;
                timer_run_d[sel_flow]  = 1'b0;
                rr_ptr_d               = flow_add(sel_flow, 1);
            end
        end

        if (init_val) begin
            ack_num_d[init_flowid]   = init_ack_num;
            pending_d[init_flowid]   = 1'b0;
            seg_cnt_d[init_flowid]   = '0;
            timer_run_d[init_flowid] = 1'b0;
        end

        // Works on the post-load view so a same-cycle load does not erase this segment
        if (upd_live) begin
            if (upd_accept) begin
                seg_new = (seg_cnt_d[upd_flowid] == 2'd3) ? 2'd3 : seg_cnt_d[upd_flowid] + 2'd1;
                ack_num_d[upd_flowid] = upd_ack_num;
                seg_cnt_d[upd_flowid] = seg_new;
                if (seg_new >= 2'd2) begin
                    pending_d[upd_flowid] = 1'b1;
                end
                if ((seg_new == 2'd1) && !timer_run_d[upd_flowid]) begin
                    timer_d[upd_flowid]     = TIMER_W'(ACK_DELAY);
                    timer_run_d[upd_flowid] = 1'b1;
                end
            end else begin
                pending_d[upd_flowid] = 1'b1;
            end
        end
    end

    // Write-first lookup: reads the value this cycle's init/upd will store
    always_comb begin
        rd_resp_ack_d = rd_resp_ack_q;
        if (rd_req_val) begin
            rd_resp_ack_d = ack_num_d[rd_req_flowid];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < int'(FLOW_CNT); f++) begin
                ack_num_q[f] <= '0;
                seg_cnt_q[f] <= '0;
                timer_q[f]   <= '0;
            end
            pending_q     <= '0;
            timer_run_q   <= '0;
            rr_ptr_q      <= '0;
            out_val_q     <= 1'b0;
            out_flowid_q  <= '0;
            out_ack_q     <= '0;
            rd_resp_val_q <= 1'b0;
            rd_resp_ack_q <= '0;
        end else begin
            ack_num_q     <= ack_num_d;
            seg_cnt_q     <= seg_cnt_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            timer_run_q   <= timer_run_d;
            rr_ptr_q      <= rr_ptr_d;
            out_val_q     <= out_val_d;
            out_flowid_q  <= out_flowid_d;
            out_ack_q     <= out_ack_d;
            rd_resp_val_q <= rd_req_val;
            rd_resp_ack_q <= rd_resp_ack_d;
        end
    end

    assign rd_resp_val     = rd_resp_val_q;
    assign rd_resp_ack_num = rd_resp_ack_q;
    assign ack_req_val     = out_val_q;
    assign ack_req_flowid  = out_flowid_q;
    assign ack_req_ack_num = out_ack_q;

endmodule

// File: tb/tb_rx_ack_scheduler.sv
// Testbench for rx_ack_scheduler: directed scenarios followed by randomized
// traffic, all checked every cycle against a deadline-based reference model.
module tb_rx_ack_scheduler;

    localparam int FLOWS = 8;
    localparam int DELAY = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_val;
    logic [2:0]  init_flowid;
    logic [31:0] init_ack_num;
    logic        rd_req_val;
    logic [2:0]  rd_req_flowid;
    logic        rd_resp_val;
    logic [31:0] rd_resp_ack_num;
    logic        upd_val;
    logic [2:0]  upd_flowid;
    logic [31:0] upd_ack_num;
    logic        upd_accept;
    logic        ack_req_val;
    logic [2:0]  ack_req_flowid;
    logic [31:0] ack_req_ack_num;
    logic        ack_req_rdy;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // Reference model: ACK numbers, pending flags, segment counts and absolute
    // timeout deadlines (-1 = no timer), plus the output request and lookup result.
    logic [31:0] m_ack  [FLOWS];
    bit          m_pend [FLOWS];
    int          m_seg  [FLOWS];
    int          m_dl   [FLOWS];
    bit          m_val;
    int          m_flow;
    logic [31:0] m_ackout;
    int          m_rr;
    bit          m_rdv;
    logic [31:0] m_rdack;
    int          cyc = 0;

    rx_ack_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .init_val        (init_val),
        .init_flowid     (init_flowid),
        .init_ack_num    (init_ack_num),
        .rd_req_val      (rd_req_val),
        .rd_req_flowid   (rd_req_flowid),
        .rd_resp_val     (rd_resp_val),
        .rd_resp_ack_num (rd_resp_ack_num),
        .upd_val         (upd_val),
        .upd_flowid      (upd_flowid),
        .upd_ack_num     (upd_ack_num),
        .upd_accept      (upd_accept),
        .ack_req_val     (ack_req_val),
        .ack_req_flowid  (ack_req_flowid),
        .ack_req_ack_num (ack_req_ack_num),
        .ack_req_rdy     (ack_req_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit          old_pend [FLOWS];
        logic [31:0] old_ack  [FLOWS];
        bit          found;
        int          sel;
        int          f;
        old_pend = m_pend;
        old_ack  = m_ack;
        found    = 1'b0;
        sel      = 0;
        if (rst) begin
            for (int i = 0; i < FLOWS; i++) begin
                m_ack[i] = 0; m_pend[i] = 0; m_seg[i] = 0; m_dl[i] = -1;
            end
            m_val = 0; m_rr = 0; m_rdv = 0;
            cyc++;
            return;
        end
        for (int i = 0; i < FLOWS; i++) begin
            if (m_dl[i] == cyc + 1) begin
                m_pend[i] = 1; m_dl[i] = -1;
            end
        end
        if (!m_val || ack_req_rdy) begin
            for (int k = 0; k < FLOWS; k++) begin
                if (!found && old_pend[(m_rr + k) % FLOWS]) begin
                    found = 1; sel = (m_rr + k) % FLOWS;
                end
            end
            m_val = found;
            if (found) begin
                m_flow = sel; m_ackout = old_ack[sel];
                m_pend[sel] = 0; m_seg[sel] = 0; m_dl[sel] = -1;
                m_rr = (sel + 1) % FLOWS;
            end
        end
        if (init_val) begin
            f = int'(init_flowid);
            m_ack[f] = init_ack_num; m_pend[f] = 0; m_seg[f] = 0; m_dl[f] = -1;
        end
        if (upd_val && !(init_val && init_flowid == upd_flowid)) begin
            f = int'(upd_flowid);
            if (upd_accept) begin
                m_ack[f] = upd_ack_num;
                if (m_seg[f] < 3) m_seg[f]++;
                if (m_seg[f] >= 2) m_pend[f] = 1;
                if (m_seg[f] == 1 && m_dl[f] < 0) m_dl[f] = cyc + 1 + DELAY;
            end else begin
                m_pend[f] = 1;
            end
        end
        m_rdv = rd_req_val;
        if (rd_req_val) m_rdack = m_ack[rd_req_flowid];
        cyc++;
    endtask

    task automatic check_outputs();
        chk("rd_resp_val", {31'd0, rd_resp_val}, {31'd0, m_rdv});
        if (m_rdv) chk("rd_resp_ack_num", rd_resp_ack_num, m_rdack);
        chk("ack_req_val", {31'd0, ack_req_val}, {31'd0, m_val});
        if (m_val) begin
            chk("ack_req_flowid", {29'd0, ack_req_flowid}, 32'(m_flow));
            chk("ack_req_ack_num", ack_req_ack_num, m_ackout);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        init_val = 0; rd_req_val = 0; upd_val = 0; upd_accept = 0;
    endtask

    task automatic drive_upd(input int f, input logic [31:0] a, input bit acc);
        upd_val = 1; upd_flowid = 3'(f); upd_ack_num = a; upd_accept = acc;
    endtask

    initial begin
        int n;
        rst = 1; ack_req_rdy = 0;
        init_flowid = 0; init_ack_num = 0; rd_req_flowid = 0;
        upd_flowid = 0; upd_ack_num = 0;
        idle();

        // Reset state
        tick(); tick();
        chk("reset_ack_req_val", {31'd0, ack_req_val}, 32'd0);
        chk("reset_rd_resp_val", {31'd0, rd_resp_val}, 32'd0);
        rst = 0;

        // Init then lookup
        init_val = 1; init_flowid = 3; init_ack_num = 1000;
        tick(); idle();
        rd_req_val = 1; rd_req_flowid = 3;
        tick(); idle();
        chk("lookup_val", {31'd0, rd_resp_val}, 32'd1);
        chk("lookup_ack", rd_resp_ack_num, 32'd1000);

        // Two accepted segments -> one ACK two cycles after the second
        ack_req_rdy = 1;
        drive_upd(2, 1100, 1); tick();
        drive_upd(2, 1200, 1); tick(); idle();
        chk("two_seg_c2_val", {31'd0, ack_req_val}, 32'd0);
        tick();
        chk("two_seg_val", {31'd0, ack_req_val}, 32'd1);
        chk("two_seg_flow", {29'd0, ack_req_flowid}, 32'd2);
        chk("two_seg_ack", ack_req_ack_num, 32'd1200);
        tick();
        chk("two_seg_once", {31'd0, ack_req_val}, 32'd0);

        // Single segment -> delayed ACK after the timeout
        drive_upd(5, 500, 1); tick(); idle();
        n = 0;
        while (!ack_req_val && n < 200) begin
            tick(); n++;
        end
        chk("delay_cycles", n, DELAY + 1);
        chk("delay_flow", {29'd0, ack_req_flowid}, 32'd5);
        chk("delay_ack", ack_req_ack_num, 32'd500);
        tick();
        chk("delay_once", {31'd0, ack_req_val}, 32'd0);

        // Duplicate ACKs under stall; flow 0 first so it fills the empty register
        rst = 1; tick(); rst = 0;
        ack_req_rdy = 0;
        drive_upd(0, 11, 0); tick();
        drive_upd(1, 22, 0); tick();
        drive_upd(6, 33, 0); tick(); idle();
        for (int i = 0; i < 8; i++) begin
            chk("stall_flow", {29'd0, ack_req_flowid}, 32'd0);
            tick();
        end
        chk("stall_val", {31'd0, ack_req_val}, 32'd1);
        ack_req_rdy = 1;
        tick();
        chk("rr_second", {29'd0, ack_req_flowid}, 32'd1);
        tick();
        chk("rr_third", {29'd0, ack_req_flowid}, 32'd6);
        tick();
        chk("rr_drained", {31'd0, ack_req_val}, 32'd0);

        // Same-cycle init and upd: init wins, no ACK scheduled
        init_val = 1; init_flowid = 4; init_ack_num = 7;
        drive_upd(4, 9, 1); tick(); idle();
        rd_req_val = 1; rd_req_flowid = 4; tick(); idle();
        chk("init_wins_ack", rd_resp_ack_num, 32'd7);
        n = 0;
        for (int i = 0; i < DELAY + 10; i++) begin
            tick();
            if (ack_req_val) n++;
        end
        chk("init_wins_no_ack", n, 32'd0);

        // Reset during stall drops the held request
        ack_req_rdy = 0;
        drive_upd(2, 77, 0); tick(); idle();
        tick();
        chk("pre_rst_val", {31'd0, ack_req_val}, 32'd1);
        rst = 1; tick(); rst = 0;
        chk("rst_drop_val", {31'd0, ack_req_val}, 32'd0);
        ack_req_rdy = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_req_val) n++;
        end
        chk("rst_no_resend", n, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            init_val     = ($urandom_range(0, 15) == 0);
            init_flowid  = 3'($urandom_range(0, FLOWS - 1));
            init_ack_num = $urandom;
            upd_val      = ($urandom_range(0, 1) == 1);
            upd_flowid   = 3'($urandom_range(0, FLOWS - 1));
            upd_ack_num  = $urandom;
            upd_accept   = ($urandom_range(0, 3) != 0);
            rd_req_val   = ($urandom_range(0, 2) == 0);
            rd_req_flowid = 3'($urandom_range(0, FLOWS - 1));
            ack_req_rdy  = ($urandom_range(0, 1) == 1);
            tick();
        end
        rst = 0; idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
